// File: rtl/i2c_config_seq.sv
// I2C configuration sequencer: walks a ROM table of {dev_addr, reg, data} entries and
// writes each one over a built-in bit-level write master, with NACK retry and delay entries.
module i2c_config_seq #(
   parameter int CLK_FREQ   = 50000000,
   parameter int I2C_FREQ   = 20000,
   parameter int ENTRIES    = 50,
   parameter int ADDR_W     = 6,
   parameter int MAX_RETRY  = 3,
   parameter int AUTO_START = 1
) (
   input  logic              CLOCK_50,
   input  logic              iRST_N,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_index,
   output logic              FPGA_I2C_SCLK,
   inout  wire               FPGA_I2C_SDAT,
   output logic [3:0]        dbgState
);

   localparam int DIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CNT_W   = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DIV - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);
   localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);

   typedef enum logic [3:0] {
      ST_IDLE, ST_FETCH, ST_LOAD, ST_DELAY, ST_START, ST_BYTE, ST_ACK, ST_STOP, ST_NEXT
   } state_t;

   state_t            state, stateN;
   logic [1:0]        q, qN;
   logic [2:0]        bitCnt, bitN;
   logic [1:0]        byteIdx, byteN;
   logic [RTY_W-1:0]  retry, retryN;
   logic [ADDR_W-1:0] index, indexN;
   logic [23:0]       entry, entryN;
   logic [15:0]       dlyCnt, dlyN;
   logic              scl, sclN;
   logic              sdaLow, sdaLowN;
   logic              ackOk, ackOkN;
   logic              doneN, errorN;
   logic [ADDR_W-1:0] errIdxN;
   logic              autoPend;
   logic [CNT_W-1:0]  divCnt;
   logic              tick;
   logic [7:0]        curByte;
   logic              sdaIn;

   // Handshake: start is a one-cycle request honoured only in idle; busy rises on the
   // following cycle and falls in the same cycle done or error is raised.
   assign busy          = (state != ST_IDLE);
   assign rom_addr      = index;
   assign FPGA_I2C_SCLK = scl;
   assign FPGA_I2C_SDAT = sdaLow ? 1'b0 : 1'bz;
   assign sdaIn         = FPGA_I2C_SDAT;
   assign dbgState      = state;
   assign tick          = busy && (divCnt == DIV_LAST);

   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         divCnt   <= '0;
         autoPend <= (AUTO_START != 0);
      end else begin
         divCnt   <= (!busy || tick) ? '0 : divCnt + 1'b1;
         autoPend <= 1'b0;
      end
   end

   always_comb begin
      case (byteIdx)
         2'd0:    curByte = entry[23:16];
         2'd1:    curByte = entry[15:8];
         default: curByte = entry[7:0];
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         state     <= ST_IDLE;
         q         <= '0;
         bitCnt    <= '0;
         byteIdx   <= '0;
         retry     <= '0;
         index     <= '0;
         entry     <= '0;
         dlyCnt    <= '0;
         scl       <= 1'b1;
         sdaLow    <= 1'b0;
         ackOk     <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_index <= '0;
      end else begin
         state     <= stateN;
         q         <= qN;
         bitCnt    <= bitN;
         byteIdx   <= byteN;
         retry     <= retryN;
         index     <= indexN;
         entry     <= entryN;
         dlyCnt    <= dlyN;
         scl       <= sclN;
         sdaLow    <= sdaLowN;
         ackOk     <= ackOkN;
         done      <= doneN;
         error     <= errorN;
         err_index <= errIdxN;
      end
   end

   always_comb begin
      stateN  = state;
      qN      = q;
      bitN    = bitCnt;
      byteN   = byteIdx;
      retryN  = retry;
      indexN  = index;
      entryN  = entry;
      dlyN    = dlyCnt;
      sclN    = scl;
      sdaLowN = sdaLow;
      ackOkN  = ackOk;
      doneN   = done;
      errorN  = error;
      errIdxN = err_index;
      case (state)
         ST_IDLE: begin
            sclN    = 1'b1;
            sdaLowN = 1'b0;
            qN      = '0;
            if (start || autoPend) begin
               stateN = ST_FETCH;
               doneN  = 1'b0;
               errorN = 1'b0;
               indexN = '0;
               retryN = '0;
            end
         end
         ST_FETCH: stateN = ST_LOAD;
         ST_LOAD: begin
            entryN = rom_data;
            qN     = '0;
            if (rom_data[23:16] == 8'hFF) begin
               dlyN   = rom_data[15:0];
               stateN = ST_DELAY;
            end else begin
               stateN = ST_START;
            end
         end
         ST_DELAY: begin
            // a zero count still consumes one tick
            if (tick) begin
               if (dlyCnt <= 16'd1) stateN = ST_NEXT;
               else                 dlyN   = dlyCnt - 16'd1;
            end
         end
         ST_START: begin
            if (tick) begin
               qN = q + 2'd1;
               case (q)
                  2'd0: begin sclN = 1'b1; sdaLowN = 1'b0; end
                  2'd1: sdaLowN = 1'b1;
                  2'd2: sclN = 1'b0;
                  2'd3: begin stateN = ST_BYTE; byteN = '0; bitN = 3'd7; end
               endcase
            end
         end
         ST_BYTE: begin
            if (tick) begin
               qN = q + 2'd1;
               case (q)
                  2'd0: begin sclN = 1'b0; sdaLowN = ~curByte[bitCnt]; end
                  2'd1: sclN = 1'b1;
                  2'd2: sclN = 1'b1;
                  2'd3: begin
                     sclN = 1'b0;
                     if (bitCnt == 3'd0) stateN = ST_ACK;
                     else                bitN   = bitCnt - 3'd1;
                  end
               endcase
            end
         end
         ST_ACK: begin
            if (tick) begin
               qN = q + 2'd1;
               case (q)
                  2'd0: begin sclN = 1'b0; sdaLowN = 1'b0; end
                  2'd1: sclN = 1'b1;
                  2'd2: ackOkN = ~sdaIn;
                  2'd3: begin
                     sclN = 1'b0;
                     // a NACK on any byte abandons the rest of the entry
                     if (!ackOk || byteIdx == 2'd2) begin
                        stateN = ST_STOP;
                     end else begin
                        byteN  = byteIdx + 2'd1;
                        bitN   = 3'd7;
                        stateN = ST_BYTE;
                     end
                  end
               endcase
            end
         end
         ST_STOP: begin
            if (tick) begin
               qN = q + 2'd1;
               case (q)
                  2'd0: begin sclN = 1'b0; sdaLowN = 1'b1; end
                  2'd1: sclN = 1'b1;
                  2'd2: sdaLowN = 1'b0;
                  2'd3: begin
                     if (ackOk) begin
                        stateN = ST_NEXT;
                     end else if (retry != RTY_MAX) begin
                        retryN = retry + 1'b1;
                        stateN = ST_START;
                     end else begin
                        errorN  = 1'b1;
                        errIdxN = index;
                        stateN  = ST_IDLE;
                     end
                  end
               endcase
            end
         end
         ST_NEXT: begin
            retryN = '0;
            if (index == LAST_IDX) begin
               doneN  = 1'b1;
               stateN = ST_IDLE;
            end else begin
               indexN = index + 1'b1;
               stateN = ST_FETCH;
            end
         end
         default: stateN = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_i2c_config_seq.sv
// Bench for i2c_config_seq: ROM + I2C slave/monitor with a scripted ACK plan, checked
// against a transaction-level model of the table walk.
`timescale 1ns/1ps
module tb_i2c_config_seq;

   localparam int DIV       = 5;
   localparam int ENTRIES   = 5;
   localparam int ADDR_W    = 3;
   localparam int MAX_RETRY = 2;
   localparam int BUDGET    = 20000;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic              start = 1'b0;
   logic [ADDR_W-1:0] romAddr;
   logic [23:0]       romData = '0;
   logic              busy, done, error;
   logic [ADDR_W-1:0] errIndex;
   logic              scl;
   wire               sda;
   logic [3:0]        dbgState;
   logic              slaveLow = 1'b0;
   logic [23:0]       rom [0:(1<<ADDR_W)-1];

   assign sda = slaveLow ? 1'b0 : 1'bz;
   pullup (sda);
   always @(posedge clk) romData <= rom[romAddr];

   i2c_config_seq #(.CLK_FREQ(400), .I2C_FREQ(20), .ENTRIES(ENTRIES), .ADDR_W(ADDR_W),
                    .MAX_RETRY(MAX_RETRY), .AUTO_START(1)) dut (
      .CLOCK_50(clk), .iRST_N(rst_n), .start(start), .rom_addr(romAddr), .rom_data(romData),
      .busy(busy), .done(done), .error(error), .err_index(errIndex),
      .FPGA_I2C_SCLK(scl), .FPGA_I2C_SDAT(sda), .dbgState(dbgState));

   // second instance without auto start and with no slave on its bus
   logic        start2 = 1'b0;
   logic [0:0]  romAddr2, errIndex2;
   logic        busy2, done2, error2, scl2;
   wire         sda2;
   logic [3:0]  dbgState2;
   pullup (sda2);

   i2c_config_seq #(.CLK_FREQ(400), .I2C_FREQ(20), .ENTRIES(2), .ADDR_W(1),
                    .MAX_RETRY(0), .AUTO_START(0)) dut2 (
      .CLOCK_50(clk), .iRST_N(rst_n), .start(start2), .rom_addr(romAddr2), .rom_data(24'h340018),
      .busy(busy2), .done(done2), .error(error2), .err_index(errIndex2),
      .FPGA_I2C_SCLK(scl2), .FPGA_I2C_SDAT(sda2), .dbgState(dbgState2));

   // scoreboard state
   int checks = 0;
   int errors = 0;
   logic [25:0] exp_q[$];
   logic [25:0] obs_q[$];
   int          expGap_q[$];
   int          gap_q[$];
   int          plan_q[$];
   int          planSrc[$];
   logic        expDone, expErr;
   int          expErrIdx;

   // monitor / slave state
   bit         active = 0, ackClk = 0, haveStop = 0, haveRise = 0;
   bit         prevScl = 1, prevSda = 1, romAddrBad = 0, bothFlag = 0;
   int         bitPos = 0, byteCnt = 0, nackAt = 3, lastStop = 0, lastRise = 0;
   int         perMin = 1000000, perMax = 0;
   logic [1:0] nByte = '0;
   logic [7:0] shreg = '0, mb0 = '0, mb1 = '0, mb2 = '0;

   always @(negedge clk) begin
      if (romAddr > ADDR_W'(ENTRIES - 1)) romAddrBad = 1;
      if (done && error) bothFlag = 1;
      if (!rst_n) begin
         active = 0; ackClk = 0; bitPos = 0; slaveLow = 1'b0;
      end else if (scl && prevScl && prevSda && !sda) begin
         active = 1; bitPos = 0; byteCnt = 0; nByte = '0; ackClk = 0; haveRise = 0;
         mb0 = '0; mb1 = '0; mb2 = '0;
         gap_q.push_back(haveStop ? cyc - lastStop : -1);
         if (plan_q.size() > 0) nackAt = plan_q.pop_front();
         else                   nackAt = 3;
      end else if (scl && prevScl && !prevSda && sda) begin
         if (active) begin
            obs_q.push_back({nByte, mb0, mb1, mb2});
            lastStop = cyc;
            haveStop = 1;
         end
         active = 0;
      end else if (active && scl && !prevScl) begin
         if (haveRise) begin
            if (cyc - lastRise < perMin) perMin = cyc - lastRise;
            if (cyc - lastRise > perMax) perMax = cyc - lastRise;
         end
         lastRise = cyc;
         haveRise = 1;
         if (!ackClk && bitPos < 8) begin
            shreg = {shreg[6:0], sda};
            bitPos++;
            if (bitPos == 8) begin
               case (byteCnt)
                  0: mb0 = shreg;
                  1: mb1 = shreg;
                  default: mb2 = shreg;
               endcase
               nByte = 2'(byteCnt + 1);
            end
         end else if (bitPos == 8) begin
            ackClk = 1;
         end
      end else if (active && !scl && prevScl) begin
         if (bitPos == 8 && !ackClk) begin
            slaveLow = (byteCnt != nackAt);
         end else if (ackClk) begin
            slaveLow = 1'b0; ackClk = 0; bitPos = 0; byteCnt++;
         end
      end
      prevScl = scl;
      prevSda = sda;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference: each entry is tried until ACKed or MAX_RETRY+1 attempts are spent;
   // the slave consumes one plan item per START (3 = ACK all, k = NACK byte k)
   task automatic build_model();
      int pi, pend, n, passes;
      bit ok, first;
      exp_q.delete(); expGap_q.delete();
      expErr = 0; expErrIdx = 0; pi = 0; pend = 0; first = 1;
      for (int e = 0; e < ENTRIES && !expErr; e++) begin
         if (rom[e][23:16] == 8'hFF) begin
            passes = (rom[e][15:0] == 16'd0) ? 1 : int'(rom[e][15:0]);
            pend += passes;
            continue;
         end
         ok = 0;
         for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
            n = (pi < planSrc.size()) ? planSrc[pi] : 3;
            pi++;
            case (n)
               0:       exp_q.push_back({2'd1, rom[e][23:16], 16'h0000});
               1:       exp_q.push_back({2'd2, rom[e][23:8], 8'h00});
               default: exp_q.push_back({2'd3, rom[e]});
            endcase
            ok = (n == 3);
            expGap_q.push_back(first ? -1 : (3 + pend) * DIV);
            first = 0;
            pend = 0;
         end
         if (!ok) begin expErr = 1; expErrIdx = e; end
      end
      expDone = !expErr;
   endtask

   task automatic prepare();
      build_model();
      plan_q = planSrc;
      obs_q.delete(); gap_q.delete();
      haveStop = 0; perMin = 1000000; perMax = 0; romAddrBad = 0; bothFlag = 0;
   endtask

   task automatic rand_table();
      int d;
      d = $urandom_range(1, ENTRIES - 2);
      for (int e = 0; e < ENTRIES; e++)
         rom[e] = {8'($urandom_range(0, 254)), 16'($urandom)};
      rom[d] = {8'hFF, 16'($urandom_range(0, 15))};
      planSrc.delete();
      for (int i = 0; i < ENTRIES * (MAX_RETRY + 1); i++) begin
         int r;
         r = $urandom_range(0, 9);
         planSrc.push_back((r < 6) ? 3 : r - 6);
      end
   endtask

   task automatic pulse_start(input string name);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({name, " busy_after_start"}, busy, 1);
      chk({name, " done_cleared"}, done, 0);
      chk({name, " error_cleared"}, error, 0);
   endtask

   task automatic finish_run(input string name);
      int n;
      for (int i = 0; i < BUDGET && busy; i++) @(negedge clk);
      chk({name, " run_timeout"}, busy, 0);
      repeat (3) @(negedge clk);
      chk({name, " done"}, done, expDone);
      chk({name, " error"}, error, expErr);
      if (expErr) chk({name, " err_index"}, errIndex, expErrIdx);
      chk({name, " bus_idle_scl"}, scl, 1);
      chk({name, " bus_idle_sda"}, sda, 1);
      chk({name, " txn_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s txn%0d", name, i), obs_q[i], exp_q[i]);
         if (expGap_q[i] >= 0 && i < gap_q.size()) begin
            checks++;
            assert (gap_q[i] >= expGap_q[i] - DIV && gap_q[i] <= expGap_q[i] + DIV) else begin
               errors++;
               $error("FAIL %s gap%0d: observed=%0d expected=%0d+-%0d", name, i, gap_q[i], expGap_q[i], DIV);
            end
         end
      end
      chk({name, " scl_period_min"}, perMin, 4 * DIV);
      chk({name, " scl_period_max"}, perMax, 4 * DIV);
      chk({name, " rom_addr_range"}, romAddrBad, 0);
      chk({name, " done_error_exclusive"}, bothFlag, 0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      rom[0] = 24'h340018; rom[1] = 24'h340118; rom[2] = 24'hFF000A;
      rom[3] = 24'h401500; rom[4] = 24'h340218;
      for (int e = ENTRIES; e < (1 << ADDR_W); e++) rom[e] = 24'h000000;
      planSrc = '{3, 3, 3, 3};
      repeat (3) @(negedge clk);
      chk("reset scl", scl, 1);
      chk("reset sda", sda, 1);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset error", error, 0);
      chk("reset err_index", errIndex, 0);
      chk("reset rom_addr", romAddr, 0);

      // run 0: auto start, every write ACKed, includes a 10-tick delay entry
      prepare();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("auto_start busy", busy, 1);
      repeat (50) @(negedge clk);
      chk("no_auto busy2", busy2, 0);
      chk("no_auto scl2", scl2, 1);
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      chk("start2 busy2", busy2, 1);
      finish_run("run0");
      chk("dut2 error", error2, 1);
      chk("dut2 done", done2, 0);
      chk("dut2 err_index", errIndex2, 0);

      // run 1: entry 1 NACKed once on the register byte; start mid-run is ignored
      planSrc = '{3, 1, 3, 3, 3};
      prepare();
      pulse_start("run1");
      for (int i = 0; i < BUDGET && obs_q.size() < 2; i++) @(negedge clk);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      finish_run("run1");

      // run 2: entry 3 NACKed on the address on every attempt
      planSrc = '{3, 3, 0, 0, 0};
      prepare();
      pulse_start("run2");
      finish_run("run2");

      for (int r = 0; r < 5; r++) begin
         rand_table();
         prepare();
         pulse_start($sformatf("rand%0d", r));
         finish_run($sformatf("rand%0d", r));
      end

      // reset in the middle of the register byte, then auto restart from index 0
      rand_table();
      planSrc = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      prepare();
      pulse_start("mid");
      for (int i = 0; i < BUDGET && !(active && byteCnt == 1 && bitPos == 3); i++) @(negedge clk);
      chk("mid reached_byte1", byteCnt, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid scl", scl, 1);
      chk("mid sda", sda, 1);
      chk("mid busy", busy, 0);
      chk("mid rom_addr", romAddr, 0);
      repeat (3) @(negedge clk);
      rand_table();
      prepare();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid restart busy", busy, 1);
      finish_run("mid_restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_config_seq.md
Name: i2c_config_seq

Overview:
- Parametrised I2C configuration sequencer: walks a table of 24-bit entries {dev_addr, reg, data} from an external synchronous ROM and writes each entry to the bus.
- Contains its own bit-level I2C write master, with no derived clock.
- Adds per-entry NACK retry, delay entries, error reporting, and re-run on demand.
- Sits beside the audio/video codec config path; drives the board I2C pins directly.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
I2C_FREQ, 20000, SCL frequency in Hz.
ENTRIES, 50, number of table entries; must be 1..2^ADDR_W.
ADDR_W, 6, ROM address width.
MAX_RETRY, 3, extra attempts per entry after a NACK (0 = no retry).
AUTO_START, 1, 1 = run the table once after reset without a start pulse.

Ports:
CLOCK_50  input  1  system clock; all logic on its rising edge.
iRST_N  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; runs the table from index 0 when not busy.
rom_addr  output  ADDR_W  table index; ROM returns rom_data 1 cycle later.
rom_data  input  24  [23:16] 7-bit addr+R/W byte, [15:8] register byte, [7:0] data byte.
busy  output  1  high while a run is in progress.
done  output  1  high after a run completes with all entries ACKed; cleared by start.
error  output  1  high after a run aborts; cleared by start.
err_index  output  ADDR_W  index of the failing entry; valid while error=1.
FPGA_I2C_SCLK  output  1  SCL, push-pull.
FPGA_I2C_SDAT  inout  1  SDA, open-drain: drives 0 or is high-Z; never drives 1.

Behaviour:
Reset (asynchronous, effective immediately, including mid-transfer):
- FPGA_I2C_SCLK=1, SDA released, busy=0, done=0, error=0, err_index=0, rom_addr=0.
- Divider and retry counters cleared.
- If AUTO_START=1, the first rising edge after iRST_N deasserts acts as a start.

Timing:
- DIV = CLK_FREQ/(4*I2C_FREQ), integer division, minimum 1.
- A quarter-period tick fires every DIV clocks while busy; the counter is held at 0 otherwise.
- All bus changes occur only on ticks. Default SCL period is 2500 clocks.

State machine:
- IDLE: waits for start. Then busy=1, done=0, error=0, index=0, retries=0 → FETCH.
- FETCH: rom_addr=index; wait 1 clock → LOAD.
- LOAD: latch rom_data.
  - If [23:16]==8'hFF (delay entry): DELAY.
  - Else START.
- DELAY: counts {reg,data} ticks, then → NEXT. Count 0 passes through in 1 tick. No bus activity.
- START, over 4 ticks: SDA=1,SCL=1 → SDA=0 → SCL=0 (hold) → BYTE with byte=0.
- BYTE: bytes are sent MSB first, 8 bits × 4 ticks each:
  - q0: SCL=0, set SDA.
  - q1: SCL=1.
  - q2: SCL=1.
  - q3: SCL=0.
- ACK: SDA released.
  - q0: SCL=0. q1: SCL=1.
  - q2: sample SDA; 0 = ACK, 1 = NACK.
  - q3: SCL=0.
  - ACK and byte<2: BYTE with byte+1.
  - ACK and byte==2: STOP with ok.
  - NACK: STOP with fail; remaining bytes skipped.
- STOP, over 4 ticks: SCL=0,SDA=0 → SCL=1 → SDA released → hold.
  - ok: → NEXT.
  - fail and retries<MAX_RETRY: retries+1 → START. Same entry; latched data is reused, no refetch.
  - fail and retries==MAX_RETRY: error=1, err_index=index, busy=0 → IDLE.
- NEXT: retries=0.
  - index==ENTRIES-1: done=1, busy=0 → IDLE.
  - Else index+1 → FETCH.

Other rules:
- start while busy is ignored.
- start and completion in the same cycle: completion wins; the start is dropped.
- Bus idle (SCL=1, SDA released) whenever in IDLE.
- Index never exceeds ENTRIES-1; no wrap.
- rom_addr holds its value outside FETCH.
- done and error are never both 1.
- Bytes per entry: 3 bus bytes. The R/W bit is whatever rom_data[16] holds; the block does not check it.

Test Plan:
- Completion and divider: CLK_FREQ=400, I2C_FREQ=20 (DIV=5), ENTRIES=3, ACKing slave model, ROM {34 00 18},{34 01 18},{40 15 00} → monitor decodes 3 transactions with exact bytes; SCL period 20 clocks; done=1, busy=0, error=0 after the last STOP.
- Single NACK: slave NACKs the first attempt of entry 1 on the reg byte, MAX_RETRY=3 → entry 1 appears twice on the bus (the first time truncated after the reg byte); run completes with done=1.
- Persistent NACK: slave NACKs dev addr 8'h40 always, MAX_RETRY=2 → 3 attempts of entry 2, then error=1, err_index=2, done=0, bus idle.
- Delay entry: ROM entry {FF 00 0A} between two writes → SCL/SDA idle for 10 ticks (50 clocks at DIV=5) ±1 tick between the two STOP/START edges.
- Start handling: AUTO_START=0; no activity after reset. A start pulse runs the table; a second start mid-run is ignored; a start after done reruns from index 0, clearing done.
- Reset mid-byte: assert iRST_N=0 during the data byte → same cycle SCLK=1, SDA high-Z, busy=0. After release with AUTO_START=1, the sequence restarts at index 0.
